// File: rtl/swervolf_sevseg_ctrl.sv
// Wishbone-mapped multiplexed seven-segment controller: hex/raw digit data, decimal
// points, per-digit blink, PWM brightness, guard blanking and double-buffered updates.
module swervolf_sevseg_ctrl #(
  parameter int N_DIGITS     = 8,
  parameter int SCAN_DIV     = 12500,
  parameter int GUARD        = 4,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [5:0]          i_wb_adr,
  input  logic [31:0]         i_wb_dat,
  input  logic [3:0]          i_wb_sel,
  input  logic                i_wb_we,
  input  logic                i_wb_cyc,
  input  logic                i_wb_stb,
  output logic [31:0]         o_wb_rdt,
  output logic                o_wb_ack,
  output logic [N_DIGITS-1:0] o_an,
  output logic [6:0]          o_seg,
  output logic                o_dp
);

  localparam int SW = $clog2(SCAN_DIV);
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  function automatic logic [6:0] f_hex_decode(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0:    s = 7'h7E;
      4'h1:    s = 7'h30;
      4'h2:    s = 7'h6D;
      4'h3:    s = 7'h79;
      4'h4:    s = 7'h33;
      4'h5:    s = 7'h5B;
      4'h6:    s = 7'h5F;
      4'h7:    s = 7'h70;
      4'h8:    s = 7'h7F;
      4'h9:    s = 7'h73;
      4'hA:    s = 7'h77;
      4'hB:    s = 7'h1F;
      4'hC:    s = 7'h4E;
      4'hD:    s = 7'h3D;
      4'hE:    s = 7'h4F;
      4'hF:    s = 7'h47;
      default: s = 7'h00;
    endcase
    return s;
  endfunction

  function automatic logic [31:0] f_merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                          input logic [3:0] sel);
    logic [31:0] m;
    for (int b = 0; b < 4; b++) begin
      m[8*b +: 8] = sel[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
    end
    return m;
  endfunction

  // Control and shadow registers
  logic                r_en;
  logic                r_raw_mode;
  logic                r_sync;
  logic [3:0]          r_bright;
  logic [N_DIGITS-1:0] r_digen;
  logic [N_DIGITS-1:0] r_dp;
  logic [N_DIGITS-1:0] r_blink;
  logic [3:0]          r_hex_sh  [N_DIGITS];
  logic [6:0]          r_raw_sh  [N_DIGITS];
  logic [3:0]          r_hex_act [N_DIGITS];
  logic [6:0]          r_raw_act [N_DIGITS];
  logic                r_pending;

  // Scan engine state
  logic [SW-1:0]       r_slot;
  logic [3:0]          r_idx;
  logic [FW-1:0]       r_frame;
  logic                r_phase;
  logic [3:0]          r_pwm;

  logic [3:0]          w_word;
  logic                w_acc;
  logic                w_wr;
  logic                w_buf_wr;
  logic [31:0]         w_rdata;
  logic [31:0]         w_wdata;
  logic                w_frame_start;
  logic                w_copy;
  logic                w_cur_digen;
  logic                w_cur_dp;
  logic                w_cur_blink;
  logic [3:0]          w_cur_hex;
  logic [6:0]          w_cur_raw;
  logic                w_lit;
  logic [N_DIGITS-1:0] w_an;
  logic [6:0]          w_seg;
  logic                w_dpn;

  assign w_word   = i_wb_adr[5:2];
  assign w_acc    = i_wb_cyc & i_wb_stb & ~o_wb_ack;
  assign w_wr     = w_acc & i_wb_we;
  assign w_buf_wr = w_wr & ((w_word == 4'd4) | (w_word == 4'd5) | (w_word[3:2] == 2'b10));
  assign w_wdata  = f_merge(w_rdata, i_wb_dat, i_wb_sel);

  assign w_frame_start = r_en & (r_idx == 4'd0) & (r_slot == SW'(0));
  assign w_copy        = ~r_sync | w_frame_start;

  // Register read mux; partial writes merge new lanes into this view
  always_comb begin
    w_rdata = 32'd0;
    case (w_word)
      4'd0:    w_rdata = {20'd0, r_bright, 5'd0, r_sync, r_raw_mode, r_en};
      4'd1:    w_rdata[N_DIGITS-1:0] = r_digen;
      4'd2:    w_rdata[N_DIGITS-1:0] = r_dp;
      4'd3:    w_rdata[N_DIGITS-1:0] = r_blink;
      4'd12:   w_rdata = {22'd0, r_pending, r_phase, 4'd0, r_idx};
      default: w_rdata = 32'd0;
    endcase
    for (int k = 0; k < N_DIGITS; k++) begin
      w_rdata[4*(k%8) +: 4] = w_rdata[4*(k%8) +: 4] |
                              ({4{w_word == 4'(4 + k / 8)}} & r_hex_sh[k]);
      w_rdata[8*(k%4) +: 7] = w_rdata[8*(k%4) +: 7] |
                              ({7{w_word == 4'(8 + k / 4)}} & r_raw_sh[k]);
    end
  end

  // Bus handshake and register writes, committed on the ack edge
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_wb_ack   <= 1'b0;
      o_wb_rdt   <= 32'd0;
      r_en       <= 1'b0;
      r_raw_mode <= 1'b0;
      r_sync     <= 1'b0;
      r_bright   <= 4'd0;
      r_digen    <= '0;
      r_dp       <= '0;
      r_blink    <= '0;
      for (int k = 0; k < N_DIGITS; k++) begin
        r_hex_sh[k] <= 4'd0;
        r_raw_sh[k] <= 7'd0;
      end
    end else begin
      o_wb_ack <= w_acc;
      o_wb_rdt <= w_acc ? w_rdata : 32'd0;
      if (w_wr) begin
        case (w_word)
          4'd0: begin
            r_en       <= w_wdata[0];
            r_raw_mode <= w_wdata[1];
            r_sync     <= w_wdata[2];
            r_bright   <= w_wdata[11:8];
          end
          4'd1:    r_digen <= w_wdata[N_DIGITS-1:0];
          4'd2:    r_dp    <= w_wdata[N_DIGITS-1:0];
          4'd3:    r_blink <= w_wdata[N_DIGITS-1:0];
          default: ;
        endcase
      end
      for (int k = 0; k < N_DIGITS; k++) begin
        if (w_wr && (w_word == 4'(4 + k / 8))) r_hex_sh[k] <= w_wdata[4*(k%8) +: 4];
        if (w_wr && (w_word == 4'(8 + k / 4))) r_raw_sh[k] <= w_wdata[8*(k%4) +: 7];
      end
    end
  end

  // Shadow-to-active transfer; a write coinciding with a frame start keeps pending set
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pending <= 1'b0;
      for (int k = 0; k < N_DIGITS; k++) begin
        r_hex_act[k] <= 4'd0;
        r_raw_act[k] <= 7'd0;
      end
    end else begin
      if (w_copy) begin
        for (int k = 0; k < N_DIGITS; k++) begin
          r_hex_act[k] <= r_hex_sh[k];
          r_raw_act[k] <= r_raw_sh[k];
        end
      end
      if (w_buf_wr && r_sync) begin
        r_pending <= 1'b1;
      end else if (w_copy) begin
        r_pending <= 1'b0;
      end
    end
  end

  // Slot, digit, frame, blink-phase and PWM counters; all held at zero while disabled
  always_ff @(posedge i_clk) begin
    if (i_rst || !r_en) begin
      r_slot  <= SW'(0);
      r_idx   <= 4'd0;
      r_frame <= FW'(0);
      r_phase <= 1'b0;
      r_pwm   <= 4'd0;
    end else begin
      r_pwm <= r_pwm + 4'd1;
      if (r_slot == SW'(SCAN_DIV - 1)) begin
        r_slot <= SW'(0);
        if (r_idx == 4'(N_DIGITS - 1)) begin
          r_idx <= 4'd0;
          if (r_frame == FW'(BLINK_FRAMES - 1)) begin
            r_frame <= FW'(0);
            r_phase <= ~r_phase;
          end else begin
            r_frame <= r_frame + FW'(1);
          end
        end else begin
          r_idx <= r_idx + 4'd1;
        end
      end else begin
        r_slot <= r_slot + SW'(1);
      end
    end
  end

  // Select the current digit's attributes without indexing past N_DIGITS
  always_comb begin
    w_cur_digen = 1'b0;
    w_cur_dp    = 1'b0;
    w_cur_blink = 1'b0;
    w_cur_hex   = 4'd0;
    w_cur_raw   = 7'd0;
    for (int k = 0; k < N_DIGITS; k++) begin
      w_cur_digen = w_cur_digen | ((r_idx == 4'(k)) & r_digen[k]);
      w_cur_dp    = w_cur_dp    | ((r_idx == 4'(k)) & r_dp[k]);
      w_cur_blink = w_cur_blink | ((r_idx == 4'(k)) & r_blink[k]);
      w_cur_hex   = w_cur_hex   | ({4{r_idx == 4'(k)}} & r_hex_act[k]);
      w_cur_raw   = w_cur_raw   | ({7{r_idx == 4'(k)}} & r_raw_act[k]);
    end
  end

  // Lit decision and active-low pin values
  always_comb begin
    w_lit = r_en & w_cur_digen & (r_slot >= SW'(GUARD)) & (r_pwm <= r_bright) &
            ~(w_cur_blink & r_phase);
    w_an  = '1;
    w_seg = 7'h7F;
    w_dpn = 1'b1;
    if (w_lit) begin
      w_an  = ~(N_DIGITS'(1'b1) << r_idx);
      w_seg = r_raw_mode ? ~w_cur_raw : ~f_hex_decode(w_cur_hex);
      w_dpn = ~w_cur_dp;
    end else begin
      w_an  = '1;
      w_seg = 7'h7F;
      w_dpn = 1'b1;
    end
  end

  // Registered display outputs
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_an  <= '1;
      o_seg <= 7'h7F;
      o_dp  <= 1'b1;
    end else begin
      o_an  <= w_an;
      o_seg <= w_seg;
      o_dp  <= w_dpn;
    end
  end

endmodule

// File: tb/tb_swervolf_sevseg_ctrl.sv
// Directed bench for swervolf_sevseg_ctrl with 4 digits, 8-cycle slots, 2-cycle guard
// and 2-frame blink; display outputs are compared every cycle against a closed-form model.
module tb_swervolf_sevseg_ctrl;

  logic        clk;
  logic        rst;
  logic [5:0]  adr;
  logic [31:0] dat;
  logic [3:0]  sel;
  logic        we;
  logic        cyc;
  logic        stb;
  logic [31:0] rdt;
  logic        ack;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [6:0] hexseg [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                              7'h7F, 7'h73, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

  // Model configuration
  logic [3:0]  m_b;
  logic        m_rawm;
  logic [3:0]  m_digen;
  logic [3:0]  m_blink;
  logic [3:0]  m_dpm;
  logic [15:0] m_hex_old;
  logic [15:0] m_hex_new;
  logic [31:0] m_rawv;
  int          m_switch;

  swervolf_sevseg_ctrl #(
    .N_DIGITS(4), .SCAN_DIV(8), .GUARD(2), .BLINK_FRAMES(2)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_wb_adr(adr), .i_wb_dat(dat), .i_wb_sel(sel),
    .i_wb_we(we), .i_wb_cyc(cyc), .i_wb_stb(stb), .o_wb_rdt(rdt), .o_wb_ack(ack),
    .o_an(an), .o_seg(seg), .o_dp(dp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wb_write(input logic [3:0] w, input logic [31:0] d, input logic [3:0] s);
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = {w, 2'b00}; dat = d; sel = s;
    @(posedge clk); #1;
    chk("wr_ack", {31'd0, ack}, 32'd1);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic wb_read(input logic [3:0] w, output logic [31:0] d);
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = {w, 2'b00}; sel = 4'hF;
    @(posedge clk); #1;
    chk("rd_ack", {31'd0, ack}, 32'd1);
    d = rdt;
    cyc = 1'b0; stb = 1'b0;
  endtask

  // Expected {an, seg, dp} for internal cycle j after enable (j < 0: still disabled)
  function automatic logic [11:0] model(input int j);
    int          slot, idx, pwm, phase;
    logic [15:0] hexv;
    logic [3:0]  digit;
    if (j < 0) return {4'hF, 7'h7F, 1'b1};
    slot  = j % 8;
    idx   = (j / 8) % 4;
    pwm   = j % 16;
    phase = (j / 64) % 2;
    hexv  = (j >= m_switch) ? m_hex_new : m_hex_old;
    digit = hexv[4*idx +: 4];
    if (m_digen[idx] && slot >= 2 && pwm <= int'(m_b) && !(m_blink[idx] && phase == 1))
      return {~(4'b0001 << idx),
              m_rawm ? ~m_rawv[8*idx +: 7] : ~hexseg[digit],
              ~m_dpm[idx]};
    return {4'hF, 7'h7F, 1'b1};
  endfunction

  task automatic run_check(input int start_j, input int n);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      chk($sformatf("disp_j%0d", start_j + c), {20'd0, an, seg, dp},
          {20'd0, model(start_j + c)});
    end
  endtask

  initial begin
    logic [31:0] d;
    rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = 6'd0; dat = 32'd0; sel = 4'd0;
    m_b = 4'd15; m_rawm = 1'b0; m_digen = 4'hF; m_blink = 4'd0; m_dpm = 4'd0;
    m_hex_old = 16'h3A10; m_hex_new = 16'h3A10; m_rawv = 32'd0; m_switch = 1 << 30;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_disp", {20'd0, an, seg, dp}, {20'd0, 4'hF, 7'h7F, 1'b1});
    chk("rst_ack", {31'd0, ack}, 32'd0);
    chk("rst_rdt", rdt, 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    for (int w = 0; w < 13; w++) begin
      wb_read(4'(w), d);
      chk($sformatf("rst_rd%0d", w), d, 32'd0);
    end
    wb_write(4'd12, 32'hFFFF_FFFF, 4'hF);
    wb_read(4'd12, d);  chk("status_ro", d, 32'd0);

    // Byte-lane gating and unused bits
    wb_write(4'd0, 32'h0000_0F07, 4'b0010);
    wb_read(4'd0, d);   chk("ctrl_lane1", d, 32'h0000_0F00);
    wb_write(4'd0, 32'h0000_00FF, 4'b0001);
    wb_read(4'd0, d);   chk("ctrl_lane0", d, 32'h0000_0F07);
    wb_write(4'd1, 32'hFFFF_FFFF, 4'hF);
    wb_read(4'd1, d);   chk("digen_mask", d, 32'h0000_000F);
    wb_write(4'd0, 32'd0, 4'hF);

    // Held strobe alternates ack
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = {4'd1, 2'b00};
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk($sformatf("b2b_ack%0d", i), {31'd0, ack}, (i % 2 == 0) ? 32'd1 : 32'd0);
    end
    cyc = 1'b0; stb = 1'b0;

    // Hex scan, full brightness, digits 0,1,A,3
    wb_write(4'd4, 32'h0000_3A10, 4'hF);
    wb_write(4'd0, 32'h0000_0F01, 4'hF);
    run_check(-1, 48);

    // Disable blanks on the next output cycle
    wb_write(4'd0, 32'd0, 4'hF);
    @(negedge clk);
    @(negedge clk);
    chk("dis_blank", {20'd0, an, seg, dp}, {20'd0, 4'hF, 7'h7F, 1'b1});

    // Raw mode with decimal point on digit 0; raw bit 7 ignored
    wb_write(4'd8, 32'h0000_00C9, 4'hF);
    wb_read(4'd8, d);   chk("raw_rd", d, 32'h0000_0049);
    wb_write(4'd2, 32'h0000_0001, 4'hF);
    m_rawm = 1'b1; m_rawv = 32'h0000_0049; m_dpm = 4'b0001;
    wb_write(4'd0, 32'h0000_0F03, 4'hF);
    run_check(-1, 33);

    // Brightness B=3
    wb_write(4'd0, 32'd0, 4'hF);
    m_rawm = 1'b0; m_b = 4'd3;
    wb_write(4'd0, 32'h0000_0301, 4'hF);
    run_check(-1, 49);

    // Sync mode: update mid-frame at idx 2, lands at next frame start
    wb_write(4'd0, 32'd0, 4'hF);
    m_b = 4'd15;
    wb_write(4'd0, 32'h0000_0F05, 4'hF);
    repeat (16) @(posedge clk);
    wb_write(4'd4, 32'h0000_5C7E, 4'hF);
    wb_read(4'd12, d);  chk("status_pend", d, 32'h0000_0202);
    m_hex_new = 16'h5C7E; m_switch = 33;
    run_check(19, 30);
    wb_read(4'd12, d);  chk("status_clr", d, 32'h0000_0002);
    wb_read(4'd4, d);   chk("hex_rd", d, 32'h0000_5C7E);
    m_hex_old = 16'h5C7E; m_switch = 1 << 30;

    // Blink digit 1 with 2-frame half-period
    wb_write(4'd0, 32'd0, 4'hF);
    wb_write(4'd3, 32'h0000_0002, 4'hF);
    m_blink = 4'b0010;
    wb_write(4'd0, 32'h0000_0F01, 4'hF);
    run_check(-1, 170);

    // Reset mid-operation
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("mid_rst_disp", {20'd0, an, seg, dp}, {20'd0, 4'hF, 7'h7F, 1'b1});
    chk("mid_rst_ack", {31'd0, ack}, 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    wb_read(4'd0, d);   chk("mid_rst_ctrl", d, 32'd0);
    wb_read(4'd3, d);   chk("mid_rst_blink", d, 32'd0);
    wb_read(4'd12, d);  chk("mid_rst_status", d, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
